// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command-driven shift/rotate/Johnson sequencer over one WIDTH-bit register.
// Optional Johnson legality check enabled by SHIFT_SEQ_JOHNSON_CHECK_EN (adds johnson_err).
module shift_seq_ctrl #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
`ifdef SHIFT_SEQ_JOHNSON_CHECK_EN
  ,
  output logic             johnson_err
`endif
);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_SHL   = 3'd2;
  localparam logic [2:0] OP_SHR   = 3'd3;
  localparam logic [2:0] OP_ROL   = 3'd4;
  localparam logic [2:0] OP_ROR   = 3'd5;
  localparam logic [2:0] OP_JOHNL = 3'd6;
  localparam logic [2:0] OP_CLR   = 3'd7;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op;
  logic [WIDTH-1:0] q_step;
  logic             cmd_is_shift;

  assign cmd_is_shift = (cmd_op >= OP_SHL) && (cmd_op <= OP_JOHNL);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_is_shift && (cmd_count != '0)) state_nxt = RUN;
          else                                   state_nxt = DONE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort || (steps_left == CNT_ONE)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    q_step = q;
    case (op)
      OP_SHL:   q_step = {q[WIDTH-2:0], ser_in};
      OP_SHR:   q_step = {ser_in, q[WIDTH-1:1]};
      OP_ROL:   q_step = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROR:   q_step = {q[0], q[WIDTH-1:1]};
      OP_JOHNL: q_step = {q[WIDTH-2:0], ~q[WIDTH-1]};
      default:  q_step = q;
    endcase
  end

`ifdef SHIFT_SEQ_JOHNSON_CHECK_EN
  localparam logic [WIDTH-1:0] Q_ONE = 1;
  logic [WIDTH-1:0] q_inv;
  logic             j_legal;
  assign q_inv = ~q;
  // A run anchored at bit0 plus one carries out cleanly, leaving no overlap.
  assign j_legal = ((q & (q + Q_ONE)) == '0) || ((q_inv & (q_inv + Q_ONE)) == '0);
`endif

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q          <= '0;
      steps_left <= '0;
      op         <= OP_NOP;
`ifdef SHIFT_SEQ_JOHNSON_CHECK_EN
      johnson_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op         <= cmd_op;
            steps_left <= cmd_is_shift ? cmd_count : '0;
            if (cmd_op == OP_LOAD) q <= cmd_data;
            if (cmd_op == OP_CLR)  q <= '0;
`ifdef SHIFT_SEQ_JOHNSON_CHECK_EN
            johnson_err <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (abort) begin
            steps_left <= '0;
          end else begin
            steps_left <= steps_left - CNT_ONE;
`ifdef SHIFT_SEQ_JOHNSON_CHECK_EN
            if ((op == OP_JOHNL) && !j_legal) begin
              q           <= '0;
              johnson_err <= 1'b1;
            end else begin
              q <= q_step;
            end
`else
            q <= q_step;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed + randomized self-checking bench for shift_seq_ctrl.
// Honors SHIFT_SEQ_JOHNSON_CHECK_EN to match the DUT build.
module tb_shift_seq_ctrl;
  localparam int W = 6;
  localparam int C = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk, clear, cmd_valid, cmd_ready, ser_in, abort, busy, done;
  logic [2:0]   cmd_op;
  logic [C-1:0] cmd_count, steps_left;
  logic [W-1:0] cmd_data, q;
`ifdef SHIFT_SEQ_JOHNSON_CHECK_EN
  logic         johnson_err;
`endif

  int tests = 0;
  int fails = 0;
  logic [W-1:0] mq;
  logic         merr;

  shift_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data),
    .ser_in(ser_in), .abort(abort), .q(q), .busy(busy), .done(done),
    .steps_left(steps_left)
`ifdef SHIFT_SEQ_JOHNSON_CHECK_EN
    , .johnson_err(johnson_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mstep(input logic [2:0] op, input logic [W-1:0] v, input logic s);
    int x;
    x = int'(v);
    case (op)
      3'd2: x = (x * 2) + int'(s);
      3'd3: x = (x / 2) + (int'(s) << (W - 1));
      3'd4: x = (x * 2) + (x >> (W - 1));
      3'd5: x = (x / 2) + ((x % 2) << (W - 1));
      3'd6: x = (x * 2) + (1 - (x >> (W - 1)));
      default: x = x;
    endcase
    return logic'(x & MASK) ? W'(x & MASK) : W'(x & MASK);
  endfunction

  function automatic bit legal_johnson(input logic [W-1:0] v);
    for (int i = 0; i <= W; i++) begin
      if (int'(v) == ((1 << i) - 1)) return 1'b1;
      if (int'(v) == (MASK ^ ((1 << i) - 1))) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic run_cmd(input logic [2:0] op, input int n, input logic [W-1:0] data,
                         input int abort_at, input logic [15:0] sers);
    int  budget;
    bit  stopped;
    bit  is_shift;
    budget = 0;
    while (!cmd_ready && budget < 20) begin
      tick();
      budget++;
    end
    chk("ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_count = C'(n); cmd_data = data;
    tick();
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_count = C'($urandom); cmd_data = W'($urandom);
    merr = 1'b0;
    if (op == 3'd1) mq = data;
    if (op == 3'd7) mq = '0;
    is_shift = (op >= 3'd2) && (op <= 3'd6);
    chk("e0_ready", cmd_ready, 0);
    chk("e0_q", q, mq);
`ifdef SHIFT_SEQ_JOHNSON_CHECK_EN
    chk("e0_jerr", johnson_err, merr);
`endif
    if (!is_shift || n == 0) begin
      chk("e0_done", done, 1);
      chk("e0_busy", busy, 0);
    end else begin
      chk("e0_busy", busy, 1);
      chk("e0_steps", steps_left, n);
      stopped = 1'b0;
      for (int k = 1; k <= n; k++) begin
        if (!stopped) begin
          ser_in = sers[k-1];
          abort = (k == abort_at);
          tick();
          if (k == abort_at) begin
            chk("abort_steps", steps_left, 0);
            chk("abort_done", done, 1);
            chk("abort_q", q, mq);
            stopped = 1'b1;
          end else begin
            if (op == 3'd6 && !legal_johnson(mq)) begin
`ifdef SHIFT_SEQ_JOHNSON_CHECK_EN
              mq = '0;
              merr = 1'b1;
`else
              mq = mstep(op, mq, sers[k-1]);
`endif
            end else begin
              mq = mstep(op, mq, sers[k-1]);
            end
            chk("step_q", q, mq);
            chk("step_left", steps_left, n - k);
            if (k == n) chk("step_done", done, 1);
            else        chk("step_busy", busy, 1);
`ifdef SHIFT_SEQ_JOHNSON_CHECK_EN
            chk("step_jerr", johnson_err, merr);
`endif
          end
          abort = 1'b0;
        end
      end
    end
    abort = 1'($urandom);
    tick();
    abort = 1'b0;
    chk("e1_done", done, 0);
    chk("e1_ready", cmd_ready, 1);
    chk("e1_busy", busy, 0);
    chk("e1_q", q, mq);
  endtask

  initial begin
    clear = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_count = '0; cmd_data = '0;
    ser_in = 1'b0; abort = 1'b0;
    mq = '0; merr = 1'b0;
    #3;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_steps", steps_left, 0);
    tick(); tick();
    clear = 1'b1;
    tick();
    chk("rel_q", q, 0);
    chk("rel_ready", cmd_ready, 1);
    chk("rel_done", done, 0);

    run_cmd(3'd1, 0, 6'b101101, 0, 16'h0);
    chk("load_val", q, 6'b101101);

    run_cmd(3'd7, 0, 6'b111111, 0, 16'h0);
    run_cmd(3'd6, 12, 6'b0, 0, 16'h0);
    chk("johnl12_q", q, 6'b000000);

    run_cmd(3'd1, 0, 6'b000001, 0, 16'h0);
    run_cmd(3'd4, 6, 6'b0, 0, 16'hffff);
    chk("rol6_q", q, 6'b000001);
    run_cmd(3'd5, 1, 6'b0, 0, 16'h0);
    chk("ror1_q", q, 6'b100000);
    run_cmd(3'd2, 3, 6'b0, 0, 16'b101);
    chk("shl3_q", q, 6'b000101);

    run_cmd(3'd7, 0, 6'b0, 0, 16'h0);
    run_cmd(3'd6, 10, 6'b0, 4, 16'h0);
    chk("abort_final_q", q, 6'b000111);

    run_cmd(3'd0, 0, 6'b111111, 0, 16'h0);
    chk("nop_q", q, 6'b000111);
    run_cmd(3'd3, 0, 6'b0, 0, 16'hffff);
    chk("shr0_q", q, 6'b000111);

    // Reset in the middle of a run
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_count = 4'd8; cmd_data = '0;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    #2 clear = 1'b0;
    #1;
    mq = '0; merr = 1'b0;
    chk("mrst_q", q, 0);
    chk("mrst_ready", cmd_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_steps", steps_left, 0);
    tick();
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_nodone", done, 0);
      chk("mrst_q_hold", q, 0);
    end

    run_cmd(3'd1, 0, 6'b010101, 0, 16'h0);
    run_cmd(3'd6, 2, 6'b0, 0, 16'h0);
`ifdef SHIFT_SEQ_JOHNSON_CHECK_EN
    chk("jchk_q", q, 6'b000001);
    chk("jchk_err", johnson_err, 1);
    run_cmd(3'd0, 0, 6'b0, 0, 16'h0);
    chk("jchk_clr", johnson_err, 0);
`else
    chk("jnochk_q", q, 6'b010110);
`endif

    for (int r = 0; r < 40; r++) begin
      logic [2:0] rop;
      int rn, ra;
      rop = 3'($urandom_range(0, 7));
      rn = $urandom_range(0, 15);
      ra = (rn > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, rn) : 0;
      run_cmd(rop, rn, W'($urandom), ra, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
Command-driven sequencer that owns a WIDTH-bit shift register and drives it through load, clear, serial shift, ring and twisted-ring (Johnson) rotations. It replaces free-running hard-wired DFF chains with one controllable register. A host issues one command at a time over a valid/ready handshake, and the block reports busy/done.

Parameters:
WIDTH, 6, register width in bits (>=2)
CNT_W, 4, width of the step-count field; max steps per command = 2^CNT_W-1

Ports:
clk  input  1  rising-edge clock
clear  input  1  asynchronous, active-low reset
cmd_valid  input  1  host presents a command
cmd_ready  output  1  block accepts a command this cycle
cmd_op  input  3  operation code (see Behaviour)
cmd_count  input  CNT_W  number of shift steps
cmd_data  input  WIDTH  parallel load value
ser_in  input  1  serial input bit for SHL/SHR
abort  input  1  terminate a running shift command
q  output  WIDTH  register contents
busy  output  1  high in RUN
done  output  1  one-cycle completion pulse
steps_left  output  CNT_W  remaining steps of the current command

Behaviour:
- Reset (clear=0, async): state=IDLE, q=0, steps_left=0, done=0, busy=0. cmd_ready=1 once state=IDLE, including during reset.
- States: IDLE, RUN, DONE. cmd_ready=1 only in IDLE. busy=1 only in RUN. done=1 only in DONE.
- Accept edge E0 = rising edge with cmd_valid&cmd_ready. cmd_op, cmd_count and cmd_data are latched at E0; later changes on these inputs are ignored.
- Opcodes: 0 NOP, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 JOHNL, 7 CLR.
- NOP, LOAD, CLR:
  - At E0: LOAD sets q<=cmd_data; CLR sets q<=0; NOP leaves q unchanged.
  - Next state is DONE. done is high for the cycle after E0, and the block returns to IDLE at E1.
- Shift ops with count N>0: at E0, steps_left<=N and next state is RUN. One step is taken per edge E1..EN, and steps_left decrements each step. At EN: steps_left=0, next state is DONE. done is high for cycle N+1; IDLE at EN+1.
- Shift ops with count N=0: no step; E0 goes straight to DONE, and q is unchanged.
- Step definitions (bit0 = LSB):
  - SHL: q<={q[W-2:0],ser_in}.
  - SHR: q<={ser_in,q[W-1:1]}.
  - ROL: q<={q[W-2:0],q[W-1]}.
  - ROR: q<={q[0],q[W-1:1]}.
  - JOHNL: q<={q[W-2:0],~q[W-1]}.
- ser_in is sampled at the edge where each step occurs.
- abort: sampled only in RUN. If abort=1 at an edge, no step is taken at that edge, the block goes to DONE and steps_left<=0. q holds its last value. abort is ignored in IDLE and DONE.
- cmd_valid in RUN or DONE is not accepted. The host holds the command until cmd_ready is high.
- Back-to-back commands: a new command is accepted at the first IDLE edge, giving a minimum 2-cycle spacing for LOAD/CLR/NOP.
- Reset mid-operation: the block immediately returns to the reset values. The command in flight is lost, and no done pulse is produced.

Optional Feature:
Macro: SHIFT_SEQ_JOHNSON_CHECK_EN.
- Defined:
  - Adds output johnson_err (1 bit, reset 0).
  - Before each JOHNL step, q is checked for being a legal Johnson code: a contiguous run of 1s anchored at bit0, or a contiguous run of 0s anchored at bit0, including all-0 and all-1.
  - If q is illegal: that step loads q<=0 instead of shifting, sets johnson_err=1, and the step still counts toward N.
  - johnson_err is sticky and clears at the next accept edge.
- Undefined: no port and no check; JOHNL shifts any value.

Test Plan:
1. Reset, then release -> q=000000, cmd_ready=1, busy=0, done=0.
2. LOAD cmd_data=101101 -> q=101101 after E0; done high exactly one cycle; cmd_ready back at E1.
3. CLR, then JOHNL N=12 -> q after each edge: 000001,000011,000111,001111,011111,111111,111110,111100,111000,110000,100000,000000. busy=1 for 12 cycles, then a single done pulse.
4. LOAD 000001, then ROL N=6 -> q=000001 at E6. ROR N=1 -> q=100000. SHL N=3 with ser_in=1,0,1 -> q=000101.
5. JOHNL N=10 from 000000 with abort=1 at E4 -> q=000111, steps_left=0, DONE next cycle, no further shifts. Separately, a reset at E2 of a run -> q=000000 and no done pulse.
6. With macro defined: LOAD 010101, then JOHNL N=2 -> E1 q=000000 and johnson_err=1, E2 q=000001; the next accepted command clears johnson_err. With macro undefined, the same stimulus gives q=101011 at E1 and q=010110 at E2.
